bus_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single system bus among 4 masters (CPU IF/MEM ports, DMA, debug).

---
 rtl/bus_rr_arbiter.sv | 151 +++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter for 4 masters with registered, active-low grants.
// Optional hold-timeout pre-emption is compiled in with `define BUS_ARB_TIMEOUT_EN.
module bus_rr_arbiter #(
  parameter int HOLD_W   = 8,
  parameter int HOLD_MAX = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] bus_owner,
  output logic       bus_busy,
  output logic       arb_timeout
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e     state_q;
  logic [3:0] grnt_q;
  logic [1:0] owner_q;
  logic       busy_q;
  logic [3:0] req;
  logic [3:0] cand;
  logic [2:0] pick;
  logic       hit;
  logic [1:0] win;
  logic       owner_req;

  assign req       = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign owner_req = req[owner_q];

  // Search owner+1 .. owner+4; the lowest offset wins, so the owner is considered last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  assign pick = rr_pick(cand, owner_q);
  assign hit  = pick[2];
  assign win  = pick[1:0];

`ifdef BUS_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] cnt_q;
  logic [3:0]        mask_q;
  logic              to_q;
  logic              preempt;

  assign cand    = req & ~mask_q;
  assign preempt = (cnt_q == HOLD_W'(HOLD_MAX - 1)) && |(cand & ~(4'b0001 << owner_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grnt_q  <= 4'hF;
      owner_q <= 2'd3;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= 4'b0000;
      to_q    <= 1'b0;
    end else begin
      to_q   <= 1'b0;
      // A mask bit survives only while that master keeps requesting.
      mask_q <= mask_q & req;
      case (state_q)
        IDLE: if (hit) begin
          state_q <= GRANT;
          owner_q <= win;
          grnt_q  <= ~(4'b0001 << win);
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
        GRANT: begin
          if (owner_req) begin
            if (preempt) begin
              owner_q <= win;
              grnt_q  <= ~(4'b0001 << win);
              to_q    <= 1'b1;
              cnt_q   <= '0;
              mask_q  <= (mask_q & req) | (4'b0001 << owner_q);
            end else if (cnt_q != HOLD_W'(HOLD_MAX)) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (hit) begin
            owner_q <= win;
            grnt_q  <= ~(4'b0001 << win);
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
            grnt_q  <= 4'hF;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb_timeout = to_q;
`else
  wire unused_cfg = ^{HOLD_W'(HOLD_MAX)};

  assign cand = req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grnt_q  <= 4'hF;
      owner_q <= 2'd3;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (hit) begin
          state_q <= GRANT;
          owner_q <= win;
          grnt_q  <= ~(4'b0001 << win);
          busy_q  <= 1'b1;
        end
        GRANT: if (!owner_req) begin
          if (hit) begin
            owner_q <= win;
            grnt_q  <= ~(4'b0001 << win);
          end else begin
            state_q <= IDLE;
            grnt_q  <= 4'hF;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb_timeout = 1'b0;
`endif

  assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt_q;
  assign bus_owner = owner_q;
  assign bus_busy  = busy_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter; the pre-emption scenario runs only when
// BUS_ARB_TIMEOUT_EN is defined (DUT built with HOLD_MAX=4).
module tb_bus_rr_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_n;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] bus_owner;
  logic       bus_busy, arb_timeout;
  logic [3:0] g;
  int checks = 0;
  int errors = 0;

  bus_rr_arbiter #(.HOLD_W(8), .HOLD_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
    .m0_grnt_(m0_grnt_), .m1_grnt_(m1_grnt_), .m2_grnt_(m2_grnt_), .m3_grnt_(m3_grnt_),
    .bus_owner(bus_owner), .bus_busy(bus_busy), .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;
  assign g = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_n = 4'hF;
    #12 reset = 1'b0;
    chk("rst_grnt", g, 4'hF);
    chk("rst_busy", {3'b0, bus_busy}, 4'h0);
    chk("rst_owner", {2'b0, bus_owner}, 4'h3);
    chk("rst_to", {3'b0, arb_timeout}, 4'h0);

    // single request from IDLE, one-edge latency
    req_n = 4'b1011;
    #1 chk("m2_before_edge", g, 4'hF);
    tick();
    chk("m2_grnt", g, 4'b1011);
    chk("m2_owner", {2'b0, bus_owner}, 4'h2);
    chk("m2_busy", {3'b0, bus_busy}, 4'h1);
    req_n = 4'hF;
    tick();
    chk("m2_rel_grnt", g, 4'hF);
    chk("m2_rel_busy", {3'b0, bus_busy}, 4'h0);
    chk("m2_rel_owner", {2'b0, bus_owner}, 4'h2);

    // a request pulse that never spans an edge is not seen
    req_n = 4'b1101;
    #2 req_n = 4'hF;
    tick();
    chk("glitch_grnt", g, 4'hF);

    // rotation 0,1,2,3,0 with every master requesting
    do_reset();
    req_n = 4'h0;
    tick();
    chk("rot_first", {2'b0, bus_owner}, 4'h0);
    chk("rot_first_g", g, 4'b1110);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] cur, nxt;
      cur = 2'(i);
      nxt = cur + 2'd1;
      tick();
      chk("rot_hold", g, ~(4'b0001 << cur));
      tick();
      req_n[cur] = 1'b1;
      tick();
      chk("rot_owner", {2'b0, bus_owner}, {2'b0, nxt});
      chk("rot_grnt", g, ~(4'b0001 << nxt));
      chk("rot_busy", {3'b0, bus_busy}, 4'h1);
      req_n[cur] = 1'b0;
    end

    // owner 1 releases with m0 and m3 waiting -> m3 first
    req_n = 4'hF;
    tick();
    chk("rel_idle", g, 4'hF);
    chk("rel_idle_owner", {2'b0, bus_owner}, 4'h0);
    req_n = 4'b1101;
    tick();
    chk("m1_grnt", g, 4'b1101);
    req_n = 4'b0100;
    tick();
    chk("m1_hold", g, 4'b1101);
    req_n = 4'b0110;
    tick();
    chk("m3_next", g, 4'b0111);
    chk("m3_owner", {2'b0, bus_owner}, 4'h3);

    // async reset mid-grant
    req_n = 4'hF;
    tick();
    chk("m3_rel", g, 4'hF);
    req_n = 4'b1110;
    tick();
    chk("m0_grnt", g, 4'b1110);
    #2 reset = 1'b1;
    #1;
    chk("async_grnt", g, 4'hF);
    chk("async_busy", {3'b0, bus_busy}, 4'h0);
    chk("async_owner", {2'b0, bus_owner}, 4'h3);
    #1 reset = 1'b0;
    tick();
    chk("after_rst_grnt", g, 4'b1110);
    chk("after_rst_owner", {2'b0, bus_owner}, 4'h0);
    req_n = 4'hF;
    tick();

`ifdef BUS_ARB_TIMEOUT_EN
    // m0 monopolises; m1 waiting -> pre-empted after m0's 4th owned cycle
    do_reset();
    req_n = 4'b1110;
    tick();
    chk("to_m0_c1", g, 4'b1110);
    req_n = 4'b1100;
    tick();
    tick();
    tick();
    chk("to_m0_c4", g, 4'b1110);
    chk("to_no_pulse", {3'b0, arb_timeout}, 4'h0);
    tick();
    chk("to_m1_grnt", g, 4'b1101);
    chk("to_pulse", {3'b0, arb_timeout}, 4'h1);
    chk("to_owner", {2'b0, bus_owner}, 4'h1);
    tick();
    chk("to_pulse_end", {3'b0, arb_timeout}, 4'h0);
    req_n = 4'b1110;
    tick();
    chk("to_m0_masked", g, 4'hF);
    req_n = 4'hF;
    tick();
    req_n = 4'b1110;
    tick();
    chk("to_m0_regrant", g, 4'b1110);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
